// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding and the
// bundle of per-stage freeze/flush/bubble controls with its canonical values.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic flush_if_id;
        logic bubble_id_exe;
        logic freeze_id_exe;
        logic freeze_exe_mem;
        logic bubble_mem_wb;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_IDLE       = 7'b000_0000;
    localparam ctrl_bundle_t CTRL_MEM_STALL  = 7'b110_0111;
    localparam ctrl_bundle_t CTRL_BRANCH     = 7'b001_1000;
    localparam ctrl_bundle_t CTRL_DATA_STALL = 7'b110_1000;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline (master: hazard/branch/SRAM status)
// and the stall controller (slave: per-stage controls and statistics).
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             forward_en;
    logic             mem_read_exe;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             bubble_id_exe;
    logic             freeze_id_exe;
    logic             freeze_exe_mem;
    logic             bubble_mem_wb;
    logic             mem_timeout;
    logic             in_mem_wait;
    logic [CNT_W-1:0] data_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;

    modport master (
        output hazard, forward_en, mem_read_exe, branch_taken, mem_req, mem_ready,
        input  freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_id_exe,
               freeze_exe_mem, bubble_mem_wb, mem_timeout, in_mem_wait,
               data_stall_cnt, mem_stall_cnt
    );

    modport slave (
        input  hazard, forward_en, mem_read_exe, branch_taken, mem_req, mem_ready,
        output freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_id_exe,
               freeze_exe_mem, bubble_mem_wb, mem_timeout, in_mem_wait,
               data_stall_cnt, mem_stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for stall statistics; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    // Count up on inc, holding at the maximum value instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= {W{1'b0}};
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges SRAM wait, taken branch and data hazard into
// per-stage pipeline controls; tracks a sticky SRAM timeout and stall counts.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    pipeline_stall_controller_if.slave     bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    state_e            r_state;
    state_e            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic              w_mem_stall;
    logic              w_data_stall;
    ctrl_bundle_t      w_ctrl;
    logic [CNT_W-1:0]  w_data_cnt;
    logic [CNT_W-1:0]  w_mem_cnt;

    // Next state and stall decode; memory wait outranks branch, branch outranks data hazard
    always_comb begin
        w_next_state = r_state;
        w_mem_stall  = 1'b0;
        w_data_stall = 1'b0;
        w_ctrl       = CTRL_IDLE;
        case (r_state)
            ST_RUN: begin
                w_mem_stall = bus.mem_req & ~bus.mem_ready;
                if (w_mem_stall) begin
                    w_next_state = ST_MEM_WAIT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                w_mem_stall = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_MEM_WAIT;
                end
            end
            default: begin
                w_mem_stall  = 1'b0;
                w_next_state = ST_RUN;
            end
        endcase
        // A taken branch squashes the ID instruction, so its hazard cannot stall
        w_data_stall = rst & ~w_mem_stall & ~bus.branch_taken & bus.hazard
                       & (~bus.forward_en | bus.mem_read_exe);
        if (!rst) begin
            w_ctrl = CTRL_IDLE;
        end else if (w_mem_stall) begin
            w_ctrl = CTRL_MEM_STALL;
        end else if (bus.branch_taken) begin
            w_ctrl = CTRL_BRANCH;
        end else if (w_data_stall) begin
            w_ctrl = CTRL_DATA_STALL;
        end else begin
            w_ctrl = CTRL_IDLE;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait-cycle counter: zero outside MEM_WAIT, saturates at the timeout value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (!bus.mem_ready && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Sticky timeout, set on the wait cycle that brings the count to MEM_TIMEOUT
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_MEM_WAIT) && !bus.mem_ready && (r_wait_cnt == WAIT_LAST)) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    sat_counter #(.W(CNT_W)) u_data_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_data_stall),
        .cnt (w_data_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_mem_stall),
        .cnt (w_mem_cnt)
    );

    assign bus.freeze_pc      = w_ctrl.freeze_pc;
    assign bus.freeze_if_id   = w_ctrl.freeze_if_id;
    assign bus.flush_if_id    = w_ctrl.flush_if_id;
    assign bus.bubble_id_exe  = w_ctrl.bubble_id_exe;
    assign bus.freeze_id_exe  = w_ctrl.freeze_id_exe;
    assign bus.freeze_exe_mem = w_ctrl.freeze_exe_mem;
    assign bus.bubble_mem_wb  = w_ctrl.bubble_mem_wb;
    assign bus.mem_timeout    = r_timeout;
    assign bus.in_mem_wait    = rst & (r_state == ST_MEM_WAIT);
    assign bus.data_stall_cnt = w_data_cnt;
    assign bus.mem_stall_cnt  = w_mem_cnt;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: two controllers (small and default parameters) share
// directed and random stimulus and are compared against a behavioural model.
module tb_pipeline_stall_controller;
    localparam int W_A = 2;
    localparam int T_A = 4;
    localparam int W_B = 16;
    localparam int T_B = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // model state
    bit m_wait;
    int m_wcyc;
    bit m_to_a, m_to_b;
    int m_dcnt_a, m_mcnt_a, m_dcnt_b, m_mcnt_b;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(W_A)) if_a ();
    pipeline_stall_controller_if #(.CNT_W(W_B)) if_b ();

    pipeline_stall_controller #(.CNT_W(W_A), .MEM_TIMEOUT(T_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pipeline_stall_controller #(.CNT_W(W_B), .MEM_TIMEOUT(T_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        return (v >= ((1 << w) - 1)) ? v : v + 1;
    endfunction

    task automatic step(input logic r, input logic hz, input logic fw, input logic ld,
                        input logic br, input logic rq, input logic rd);
        bit mem, ds;
        logic [6:0] exp_ctrl, obs_a, obs_b;
        @(negedge clk);
        rst = r;
        if_a.hazard = hz; if_a.forward_en = fw; if_a.mem_read_exe = ld;
        if_a.branch_taken = br; if_a.mem_req = rq; if_a.mem_ready = rd;
        if_b.hazard = hz; if_b.forward_en = fw; if_b.mem_read_exe = ld;
        if_b.branch_taken = br; if_b.mem_req = rq; if_b.mem_ready = rd;
        #1;
        mem = r && (m_wait ? !rd : (rq && !rd));
        ds  = r && !mem && !br && hz && (!fw || ld);
        // order: freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_id_exe, freeze_exe_mem, bubble_mem_wb
        if (!r)          exp_ctrl = 7'b000_0000;
        else if (mem)    exp_ctrl = 7'b110_0111;
        else if (br)     exp_ctrl = 7'b001_1000;
        else if (ds)     exp_ctrl = 7'b110_1000;
        else             exp_ctrl = 7'b000_0000;
        obs_a = {if_a.freeze_pc, if_a.freeze_if_id, if_a.flush_if_id, if_a.bubble_id_exe,
                 if_a.freeze_id_exe, if_a.freeze_exe_mem, if_a.bubble_mem_wb};
        obs_b = {if_b.freeze_pc, if_b.freeze_if_id, if_b.flush_if_id, if_b.bubble_id_exe,
                 if_b.freeze_id_exe, if_b.freeze_exe_mem, if_b.bubble_mem_wb};
        check_eq("ctrl_a", 32'(obs_a), 32'(exp_ctrl));
        check_eq("ctrl_b", 32'(obs_b), 32'(exp_ctrl));
        if (r) begin
            check_eq("in_wait_a", 32'(if_a.in_mem_wait), 32'(m_wait));
            check_eq("in_wait_b", 32'(if_b.in_mem_wait), 32'(m_wait));
        end else begin
            check_eq("rst_wait_a", 32'(if_a.in_mem_wait), 32'd0);
        end
        check_eq("dcnt_a", 32'(if_a.data_stall_cnt), 32'(m_dcnt_a));
        check_eq("mcnt_a", 32'(if_a.mem_stall_cnt), 32'(m_mcnt_a));
        check_eq("dcnt_b", 32'(if_b.data_stall_cnt), 32'(m_dcnt_b));
        check_eq("mcnt_b", 32'(if_b.mem_stall_cnt), 32'(m_mcnt_b));
        check_eq("tmo_a", 32'(if_a.mem_timeout), 32'(m_to_a));
        check_eq("tmo_b", 32'(if_b.mem_timeout), 32'(m_to_b));
        @(posedge clk);
        if (!r) begin
            m_wait = 1'b0; m_wcyc = 0; m_to_a = 1'b0; m_to_b = 1'b0;
            m_dcnt_a = 0; m_mcnt_a = 0; m_dcnt_b = 0; m_mcnt_b = 0;
        end else begin
            if (mem) begin
                m_mcnt_a = sat_inc(m_mcnt_a, W_A);
                m_mcnt_b = sat_inc(m_mcnt_b, W_B);
            end
            if (ds) begin
                m_dcnt_a = sat_inc(m_dcnt_a, W_A);
                m_dcnt_b = sat_inc(m_dcnt_b, W_B);
            end
            if (m_wait) begin
                if (rd) begin
                    m_wait = 1'b0;
                end else begin
                    m_wcyc++;
                    if (m_wcyc >= T_A) m_to_a = 1'b1;
                    if (m_wcyc >= T_B) m_to_b = 1'b1;
                end
            end else if (rq && !rd) begin
                m_wait = 1'b1;
                m_wcyc = 0;
            end
        end
    endtask

    initial begin
        m_wait = 1'b0; m_wcyc = 0; m_to_a = 1'b0; m_to_b = 1'b0;
        m_dcnt_a = 0; m_mcnt_a = 0; m_dcnt_b = 0; m_mcnt_b = 0;
        // reset with activity on the inputs: controls must stay low
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // data hazard without forwarding, then count visible
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // forwarding hides non-load hazard; load-use still stalls
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // three-cycle SRAM wait then release
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // branch overrides data hazard
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // branch during wait, then in the ready cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        // request and ready together: no stall
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        // long wait trips both timeouts; reset mid-wait clears everything
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // drive the small counter into saturation
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
